router_reg: RTL

- Datapath register stage of the 1-to-3 packet router, directly downstream of the router control FSM.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header, steers payload bytes to the FIFO write bus, and holds a byte while the FIFO is full.
- Accumulates and checks parity; produces parity_done, low_packet_valid and err back to the FSM and top level.

---
 rtl/router_pkg.sv | 42 ++++
 rtl/router_parity_chk.sv | 55 +++++
 rtl/router_reg.sv | 94 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router datapath register stage and its control FSM.
// Holds the byte width default, the reserved address and the FSM state encodings.
package router_pkg;

    localparam int ROUTER_DATA_WIDTH = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } fsm_state_t;

    // Datapath operation for one cycle, after resolving overlapping FSM strobes.
    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_DECODE     = 3'd1,
        OP_FIRST      = 3'd2,
        OP_LOAD       = 3'd3,
        OP_AFTER_FULL = 3'd4,
        OP_FULL       = 3'd5
    } reg_op_t;

    function automatic reg_op_t resolve_op(input logic detect_add, input logic lfd_state,
                                           input logic ld_state, input logic laf_state,
                                           input logic full_state);
        reg_op_t op;
        op = OP_HOLD;
        if (detect_add)      op = OP_DECODE;
        else if (lfd_state)  op = OP_FIRST;
        else if (ld_state)   op = OP_LOAD;
        else if (laf_state)  op = OP_AFTER_FULL;
        else if (full_state) op = OP_FULL;
        return op;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running parity over header and payload, captured packet parity byte,
// and the error flag raised when the two disagree at the check point.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  reg_op_t               op,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic                  parity_done,
    input  logic                  rst_int_reg,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;

    // Payload bytes count once when accepted, whether they go to dout or the hold byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_parity <= '0;
        end else if (op == OP_DECODE) begin
            int_parity <= '0;
        end else if (op == OP_FIRST) begin
            int_parity <= int_parity ^ header;
        end else if (op == OP_LOAD && pkt_valid) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_parity <= '0;
        end else if (op == OP_DECODE) begin
            pkt_parity <= '0;
        end else if (op == OP_LOAD && !pkt_valid) begin
            pkt_parity <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (op == OP_DECODE && pkt_valid) begin
            err <= 1'b0;
        end else if (rst_int_reg && parity_done) begin
            err <= (int_parity != pkt_parity);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, steers bytes onto the
// FIFO write bus, parks a byte while the FIFO is full, and tracks packet end.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err
);

    reg_op_t               op;
    logic [DATA_WIDTH-1:0] header;
    logic [DATA_WIDTH-1:0] hold;

    assign op = resolve_op(detect_add, lfd_state, ld_state, laf_state, full_state);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header <= '0;
        end else if (op == OP_DECODE && pkt_valid && data_in[1:0] != ADDR_INVALID) begin
            header <= data_in;
        end
    end

    // A byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= '0;
            hold <= '0;
        end else begin
            case (op)
                OP_FIRST: dout <= header;
                OP_LOAD: begin
                    if (fifo_full) hold <= data_in;
                    else           dout <= data_in;
                end
                OP_AFTER_FULL: dout <= hold;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (op == OP_LOAD && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end
    end

    // A parity byte parked behind a full FIFO is only done once it is replayed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (op == OP_DECODE) begin
            parity_done <= 1'b0;
        end else if (op == OP_LOAD && !fifo_full && !pkt_valid) begin
            parity_done <= 1'b1;
        end else if (op == OP_AFTER_FULL && low_packet_valid && !parity_done) begin
            parity_done <= 1'b1;
        end
    end

    router_parity_chk #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_chk (
        .clock      (clock),
        .reset      (reset),
        .op         (op),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .header     (header),
        .parity_done(parity_done),
        .rst_int_reg(rst_int_reg),
        .err        (err)
    );

endmodule
